// File: rtl/signed_divider_if.sv
// Operand/result bundle for signed_divider. The controller drives the master side;
// the divider implements the slave side.
interface signed_divider_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             overflow;
   logic             div_zero;
   logic             negative;
   logic             zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, overflow, div_zero, negative, zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, overflow, div_zero, negative, zero
   );
endinterface

// File: rtl/signed_divider.sv
// Restoring shift-subtract signed divider: WIDTH+1 cycles accept-to-done, start ignored while busy.
// Optional SIGNED_DIVIDER_EARLY_EXIT_EN: zero divisor/dividend finishes one cycle after acceptance.
module signed_divider #(
   parameter int WIDTH = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   signed_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] raw_q;
   logic             qsign_q;
   logic             rsign_q;
   logic             dz_q;
   logic             ovf_q;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             overflow_q;
   logic             div_zero_q;
   logic             negative_q;
   logic             zero_q;

   logic [WIDTH-1:0] dvd_abs_d;
   logic [WIDTH-1:0] dvs_abs_d;
   logic [WIDTH:0]   rem_sh_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH-1:0] q_fix_d;
   logic [WIDTH-1:0] r_fix_d;
   logic             dz_d;
   logic             ovf_d;
   logic             early_d;

   always_comb begin
      // The magnitude of the most negative value is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
      dvd_abs_d = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
      dvs_abs_d = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
      dz_d      = (bus.divisor == '0);
      ovf_d     = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
`ifdef SIGNED_DIVIDER_EARLY_EXIT_EN
      early_d   = dz_d || (bus.dividend == '0);
`else
      early_d   = 1'b0;
`endif
      rem_sh_d  = {rem_q, dvd_q[WIDTH-1]};
      trial_d   = rem_sh_d - {1'b0, dvs_q};
      q_fix_d   = qsign_q ? (~quo_q + 1'b1) : quo_q;
      r_fix_d   = rsign_q ? (~rem_q + 1'b1) : rem_q;
      if (dz_q) begin
         q_fix_d = '1;
         r_fix_d = raw_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         raw_q       <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         overflow_q  <= 1'b0;
         div_zero_q  <= 1'b0;
         negative_q  <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  dvd_q   <= dvd_abs_d;
                  dvs_q   <= dvs_abs_d;
                  raw_q   <= bus.dividend;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  cnt_q   <= '0;
                  qsign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  rsign_q <= bus.dividend[WIDTH-1];
                  dz_q    <= dz_d;
                  ovf_q   <= ovf_d;
                  busy_q  <= 1'b1;
                  state_q <= early_d ? FIX : RUN;
               end
            end
            RUN: begin
               dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
               if (!trial_d[WIDTH]) begin
                  rem_q <= trial_d[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= rem_sh_d[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quotient_q  <= q_fix_d;
               remainder_q <= r_fix_d;
               overflow_q  <= ovf_q;
               div_zero_q  <= dz_q;
               negative_q  <= q_fix_d[WIDTH-1];
               zero_q      <= (q_fix_d == '0);
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.overflow  = overflow_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.negative  = negative_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_signed_divider.sv
// Bench for signed_divider: directed cases, protocol corner cases and random operands
// checked against an integer-arithmetic reference.
module tb_signed_divider;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   signed_divider_if #(.WIDTH(W)) bus ();
   signed_divider #(.WIDTH(W)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic ovf, output logic dz);
      int ai;
      int bi;
      ai  = int'($signed(a));
      bi  = int'($signed(b));
      ovf = 1'b0;
      dz  = 1'b0;
      if (bi == 0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (ai == -(2 ** (W - 1)) && bi == -1) begin
         q   = a;
         r   = '0;
         ovf = 1'b1;
      end else begin
         q = W'(ai / bi);
         r = W'(ai % bi);
      end
   endfunction

   function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_DIVIDER_EARLY_EXIT_EN
      if (a == '0 || b == '0) return 1;
`endif
      return W + 1;
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      bus.start = 1'b0;
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_check(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         ovf;
      logic         dz;
      int           n;
      model(a, b, q, r, ovf, dz);
      n = 0;
      while (!bus.done && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
      if (bus.done) begin
         chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat(a, b)));
         chk({tag, "_quotient"}, 32'(bus.quotient), 32'(q));
         chk({tag, "_remainder"}, 32'(bus.remainder), 32'(r));
         chk({tag, "_flags"}, {28'd0, bus.overflow, bus.div_zero, bus.negative, bus.zero},
             {28'd0, ovf, dz, q[W-1], (q == '0)});
         chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           t_prev;
      int           t_now;
      int           ndone;
      int           n;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {22'd0, bus.busy, bus.done, bus.overflow, bus.div_zero, bus.negative,
          bus.zero, 2'd0, bus.quotient | bus.remainder}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      start_op(8'd100, 8'd7);         wait_check(8'd100, 8'd7, "p100_d7");
      start_op(8'h9C, 8'd7);          wait_check(8'h9C, 8'd7, "m100_d7");
      start_op(8'd100, 8'hF9);        wait_check(8'd100, 8'hF9, "p100_dm7");
      start_op(8'h80, 8'hFF);         wait_check(8'h80, 8'hFF, "min_dm1");
      start_op(8'd3, 8'd5);           wait_check(8'd3, 8'd5, "p3_d5");
      start_op(8'd5, 8'd0);           wait_check(8'd5, 8'd0, "p5_d0");
      start_op(8'hFB, 8'd0);          wait_check(8'hFB, 8'd0, "m5_d0");
      start_op(8'd0, 8'hFD);          wait_check(8'd0, 8'hFD, "zero_dvd");
      start_op(8'h80, 8'd1);          wait_check(8'h80, 8'd1, "min_d1");
      start_op(8'h7F, 8'h80);         wait_check(8'h7F, 8'h80, "max_dmin");

      // A start pulse mid-operation must be dropped entirely.
      start_op(8'd100, 8'd7);
      repeat (2) begin @(posedge clk); #1; end
      bus.start    = 1'b1;
      bus.dividend = 8'd50;
      bus.divisor  = 8'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_check(8'd100, 8'd7, "ignored_start");
      ndone = 0;
      repeat (14) begin @(posedge clk); #1; if (bus.done) ndone++; end
      chk("no_queued_op", 32'(ndone), 32'd0);

      // Held start: back-to-back results every W+2 cycles.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'hEC;
      bus.divisor  = 8'd6;
      t_prev = -1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         @(posedge clk); #1;
         while (!bus.done && n < 30) begin @(posedge clk); #1; n++; end
         chk("held_done_seen", 32'(bus.done), 32'd1);
         chk("held_quotient", 32'(bus.quotient), 32'(8'hFD));
         t_now = cyc;
         if (t_prev >= 0) chk("held_period", 32'(t_now - t_prev), 32'(W + 2));
         t_prev = t_now;
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("held_release_idle", 32'(bus.busy), 32'd0);

      // Reset during RUN aborts without a done pulse.
      start_op(8'd77, 8'hFD);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_outputs", {22'd0, bus.busy, bus.done, bus.overflow, bus.div_zero, bus.negative,
          bus.zero, 2'd0, bus.quotient | bus.remainder}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (12) begin @(posedge clk); #1; if (bus.done || bus.busy) ndone++; end
      chk("abort_quiet", 32'(ndone), 32'd0);
      start_op(8'd100, 8'd7);         wait_check(8'd100, 8'd7, "after_abort");

      for (int i = 0; i < 60; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: ra = 8'h80;
            2: rb = 8'hFF;
            3: ra = '0;
            default: ;
         endcase
         start_op(ra, rb);
         wait_check(ra, rb, "random");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
